gpu_pixel_writer: RTL



---
 rtl/gpu_pixel_writer_pkg.sv | 44 ++++
 rtl/gpu_pixel_writer_if.sv | 31 +++
 rtl/gpu_pixel_writer_fifo.sv | 50 +++++
 rtl/gpu_pixel_writer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/gpu_pixel_writer_pkg.sv
// Shared definitions for the pixel writer and later raster stages: framebuffer
// geometry, pixel/word structs, writer FSM states and the address helper.
package gpu_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;
  localparam int ADDR_BITS    = 19;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } pixel_t;

  typedef struct packed {
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } fb_word_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    fb_word_t             data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } writer_state_t;

  // Raw linear address; out-of-range coordinates alias rather than saturate.
  function automatic logic [ADDR_BITS-1:0] pixel_addr(
    input logic [WIDTH_BITS-1:0]  x,
    input logic [HEIGHT_BITS-1:0] y
  );
    return ADDR_BITS'(y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(x);
  endfunction

endpackage

// File: rtl/gpu_pixel_writer_if.sv
// Pixel-in / SRAM-write-out bundle of the pixel writer. Both sides use
// valid/ready-style handshakes: a pixel moves on a rising edge with
// pix_valid_i && pix_ready_o; a write completes on a rising edge with
// mem_req_o && mem_ack_i, and addr/wdata stay stable while req waits for ack.
interface gpu_pixel_writer_if;
  import gpu_pkg::*;

  logic                      pix_valid_i;
  logic                      pix_ready_o;
  logic [WIDTH_BITS-1:0]     x_i;
  logic [HEIGHT_BITS-1:0]    y_i;
  logic [CHANNEL_BITS-1:0]   r_i;
  logic [CHANNEL_BITS-1:0]   g_i;
  logic [CHANNEL_BITS-1:0]   b_i;
  logic                      mem_req_o;
  logic [ADDR_BITS-1:0]      mem_addr_o;
  logic [3*CHANNEL_BITS-1:0] mem_wdata_o;
  logic                      mem_ack_i;

  // Environment view: rasterizer plus SRAM controller.
  modport master (
    output pix_valid_i, x_i, y_i, r_i, g_i, b_i, mem_ack_i,
    input  pix_ready_o, mem_req_o, mem_addr_o, mem_wdata_o
  );

  // Writer view.
  modport slave (
    input  pix_valid_i, x_i, y_i, r_i, g_i, b_i, mem_ack_i,
    output pix_ready_o, mem_req_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/gpu_pixel_writer_fifo.sv
// Generic synchronous FIFO (power-of-two depth) with first-word-fall-through
// head, push/pop/full/empty/count. Push when full and pop when empty are ignored.
module gpu_pixel_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Turns rasterizer (x, y, colour) pixels into framebuffer SRAM writes via a small
// FIFO and a req/ack port. Optional GPU_PIXEL_CLIP_EN drops off-screen pixels.
module gpu_pixel_writer
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  gpu_pixel_writer_if.slave   bus,
  output logic                busy_o,
  output writer_state_t       state_dbg
`ifdef GPU_PIXEL_CLIP_EN
  ,
  output logic [15:0]         clip_cnt_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pixel_t        pix_in;
  fifo_entry_t   push_entry, head;
  logic          hs, push_fifo, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_nxt;

  writer_state_t state_q, state_nxt;
  logic          req_q, req_nxt, busy_q;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [3*CHANNEL_BITS-1:0] wdata_q;

  always_comb begin
    pix_in          = '{x: bus.x_i, y: bus.y_i, r: bus.r_i, g: bus.g_i, b: bus.b_i};
    push_entry.addr = pixel_addr(pix_in.x, pix_in.y);
    push_entry.data = '{r: pix_in.r, g: pix_in.g, b: pix_in.b};
  end

  assign bus.pix_ready_o = !fifo_full;
  assign hs              = bus.pix_valid_i && bus.pix_ready_o;

`ifdef GPU_PIXEL_CLIP_EN
  logic        in_range;
  logic [15:0] clip_cnt_q;

  assign in_range  = (bus.x_i < WIDTH_BITS'(WIDTH)) && (bus.y_i < HEIGHT_BITS'(HEIGHT));
  assign push_fifo = hs && in_range;

  // Off-screen pixels complete their handshake but only bump the counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                 clip_cnt_q <= '0;
    else if (hs && !in_range && clip_cnt_q != 16'hFFFF) clip_cnt_q <= clip_cnt_q + 16'd1;
  end
  assign clip_cnt_o = clip_cnt_q;
`else
  assign push_fifo = hs;
`endif

  gpu_pixel_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push_fifo),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_nxt = WRITE;
      WRITE:   if (bus.mem_ack_i && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Popping always coincides with loading the head into the output register.
  always_comb begin
    pop     = 1'b0;
    req_nxt = req_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          req_nxt = 1'b1;
        end
      end
      WRITE: begin
        if (bus.mem_ack_i) begin
          if (!fifo_empty) pop = 1'b1;
          else             req_nxt = 1'b0;
        end
      end
      default: begin
        pop     = 1'b0;
        req_nxt = 1'b0;
      end
    endcase
  end

  assign count_nxt = fifo_count + CW'(push_fifo) - CW'(pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      req_q  <= req_nxt;
      busy_q <= (count_nxt != '0) || req_nxt;
      if (pop) begin
        addr_q  <= head.addr;
        wdata_q <= head.data;
      end
    end
  end

  assign bus.mem_req_o   = req_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign busy_o          = busy_q;
  assign state_dbg       = state_q;

endmodule
